mm_exec_sequencer: RTL

Multi-cycle operand/writeback sequencer for the memory-memory datapath. It fetches both source operands from data memory over one request/acknowledge port and latches them into the ALU operand registers. It drives the combinational ALU for one cycle, captures ALUOUT and cmp into result/flag registers, then either writes the result back to memory (ALU ops) or reports branch outcome (compare ops). It sits between instruction decode (upstream) and the ALU/data memory (downstream).

---
 rtl/mm_exec_sequencer_pkg.sv | 40 ++++
 rtl/mm_exec_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mm_exec_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mm_exec_sequencer_pkg
// Shared definitions for the memory-memory execute sequencer:
//   - default datapath / address widths
//   - sequencer state encoding (3-bit enum)
//   - funct3 opcode constants shared with the ALU and instruction decode
// -----------------------------------------------------------------------------
package mm_exec_sequencer_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4,
        ST_DONE = 3'd5
    } seq_state_e;

    // ALU operations (is_branch = 0)
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SUB  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_OR   = 3'd5;
    localparam logic [2:0] F3_AND  = 3'd6;
    localparam logic [2:0] F3_SLL  = 3'd7;

    // Compare operations (is_branch = 1); the ALU drives cmp from these
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd2;
    localparam logic [2:0] F3_BLTU = 3'd3;
    localparam logic [2:0] F3_BGE  = 3'd4;
    localparam logic [2:0] F3_BGEU = 3'd5;

endpackage

// File: rtl/mm_exec_sequencer.sv
// -----------------------------------------------------------------------------
// mm_exec_sequencer
// Multi-cycle operand fetch / execute / writeback sequencer for the
// memory-memory datapath. Reads source A and B from data memory, presents
// them to the external combinational ALU for one cycle, latches the ALU
// result and compare flag, then writes the result back (ALU ops) or just
// reports the compare outcome (branch ops).
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 one-cycle request, only honoured in IDLE
//   is_branch_i, funct3_i   operation kind / select, latched at start
//   addr_a/b/d_i            source A, source B, destination addresses
//   busy_o, done_o          busy outside IDLE, one-cycle completion pulse
//   taken_o, result_o       latched ALU compare flag and result
//   mem_*                   single request/acknowledge data-memory port
//   alu_a/b_o, alu_funct3_o operand and select registers feeding the ALU
//   alu_out_i, alu_cmp_i    combinational ALU result and compare flag
// -----------------------------------------------------------------------------
module mm_exec_sequencer
    import mm_exec_sequencer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              is_branch_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic [ADDR_W-1:0] addr_d_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              taken_o,
    output logic [WIDTH-1:0]  result_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WIDTH-1:0]  mem_wdata_o,
    input  logic [WIDTH-1:0]  mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [WIDTH-1:0]  alu_a_o,
    output logic [WIDTH-1:0]  alu_b_o,
    output logic [2:0]        alu_funct3_o,
    input  logic [WIDTH-1:0]  alu_out_i,
    input  logic              alu_cmp_i
);

    seq_state_e state_q, state_d;

    logic              is_branch_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q, addr_d_q;
    logic [WIDTH-1:0]  alu_a_q, alu_b_q, result_q;
    logic              taken_q;

    // Register-load strobes decoded by the FSM
    logic ld_cmd, ld_a, ld_b, ld_res;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode. Memory outputs are pure functions of the
    // state and latched addresses, so they stay stable until ack by design.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        ld_cmd     = 1'b0;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        ld_res     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    ld_cmd  = 1'b1;
                    state_d = ST_RD_A;
                end
            end
            ST_RD_A: begin
                mem_req_o  = 1'b1;
                mem_addr_o = addr_a_q;
                if (mem_ack_i) begin
                    ld_a    = 1'b1;
                    state_d = ST_RD_B;
                end
            end
            ST_RD_B: begin
                mem_req_o  = 1'b1;
                mem_addr_o = addr_b_q;
                if (mem_ack_i) begin
                    ld_b    = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ld_res  = 1'b1;
                state_d = is_branch_q ? ST_DONE : ST_WB;
            end
            ST_WB: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = addr_d_q;
                if (mem_ack_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Command, operand and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            is_branch_q <= 1'b0;
            funct3_q    <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            addr_d_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            result_q    <= '0;
            taken_q     <= 1'b0;
        end else begin
            if (ld_cmd) begin
                is_branch_q <= is_branch_i;
                funct3_q    <= funct3_i;
                addr_a_q    <= addr_a_i;
                addr_b_q    <= addr_b_i;
                addr_d_q    <= addr_d_i;
            end
            if (ld_a) begin
                alu_a_q <= mem_rdata_i;
            end
            if (ld_b) begin
                alu_b_q <= mem_rdata_i;
            end
            if (ld_res) begin
                result_q <= alu_out_i;
                taken_q  <= alu_cmp_i;
            end
        end
    end

    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_funct3_o = funct3_q;
    assign result_o     = result_q;
    assign taken_o      = taken_q;
    assign mem_wdata_o  = result_q;

endmodule
